// File: rtl/seq_store.sv
// seq_store: circular result store with a browse cursor.
// Accepts error-free results into a DEPTH-entry ring. It latches the most recent
// nonzero error code and presents one stored entry at a time on rd_data.
module seq_store #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 10,
  parameter int ERR_W     = 2,
  parameter int OVERWRITE = 0,
  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ERR_W-1:0]  wr_err,
  input  logic              nxt,
  input  logic              prv,
  output logic [DATA_W-1:0] rd_data,
  output logic [IW-1:0]     rd_idx,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic [ERR_W-1:0]  err_out,
  output logic              ovf
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [IW-1:0] ONE_I   = IW'(1);

  // (base + off) mod DEPTH without a power-of-two mask; base < DEPTH and off <= DEPTH
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [CW-1:0] off);
    logic [CW:0] sum_s;
    sum_s = (CW + 1)'(base) + {1'b0, off};
    if (sum_s >= {1'b0, DEPTH_C}) begin
      sum_s = sum_s - {1'b0, DEPTH_C};
    end else begin
      sum_s = sum_s;
    end
    return sum_s[IW-1:0];
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;
  logic [IW-1:0]     head_r, head_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic [IW-1:0]     wr_addr_s, rd_addr_s;
  logic [CW-1:0]     count_r, count_s;
  logic [ERR_W-1:0]  err_r, err_s;
  logic              ovf_r, ovf_s;
  logic              mem_we_s;
  logic              full_s;

  assign full_s    = (count_r == DEPTH_C);
  assign rd_addr_s = wrap_add(idx_r == {IW{1'b0}} ? head_r : head_r, CW'(idx_r));

  // Next-state decode: write/overflow policy, error latch and cursor stepping
  always_comb begin
    head_s    = head_r;
    count_s   = count_r;
    err_s     = err_r;
    ovf_s     = ovf_r;
    idx_s     = idx_r;
    mem_we_s  = 1'b0;
    wr_addr_s = wrap_add(head_r, count_r);

    if (wr_en) begin
      if (wr_err == {ERR_W{1'b0}}) begin
        if (!full_s) begin
          mem_we_s = 1'b1;
          count_s  = count_r + ONE_C;
        end else if (OVERWRITE != 0) begin
          // replace the oldest entry and slide the window forward
          mem_we_s  = 1'b1;
          wr_addr_s = head_r;
          head_s    = wrap_add(head_r, ONE_C);
          ovf_s     = 1'b1;
        end else begin
          ovf_s = 1'b1;
        end
      end else begin
        err_s = wr_err;
      end
    end else begin
      mem_we_s = 1'b0;
    end

    // cursor uses the count from before this cycle's write
    if (count_r == {CW{1'b0}}) begin
      idx_s = {IW{1'b0}};
    end else if (nxt && !prv) begin
      idx_s = (CW'(idx_r) == count_r - ONE_C) ? {IW{1'b0}} : idx_r + ONE_I;
    end else if (prv && !nxt) begin
      idx_s = (idx_r == {IW{1'b0}}) ? IW'(count_r - ONE_C) : idx_r - ONE_I;
    end else begin
      idx_s = idx_r;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {IW{1'b0}};
      count_r <= {CW{1'b0}};
      idx_r   <= {IW{1'b0}};
      err_r   <= {ERR_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      head_r  <= head_s;
      count_r <= count_s;
      idx_r   <= idx_s;
      err_r   <= err_s;
      ovf_r   <= ovf_s;
    end
  end

  // Entry storage; contents are never cleared because count gates visibility
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

  // Registered view of the entry under the cursor (one cycle behind the cursor)
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (count_r == {CW{1'b0}}) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  assign rd_data = rd_data_r;
  assign rd_idx  = idx_r;
  assign count   = count_r;
  assign empty   = (count_r == {CW{1'b0}});
  assign full    = full_s;
  assign err_out = err_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_seq_store.sv
// Bench for seq_store: a vector table checked through a scoreboard queue on two
// instances (drop and overwrite policies), followed by a hand-written fill/wrap sequence.
module tb_seq_store;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [1:0]  wr_err = 2'b00;
  logic        nxt = 1'b0;
  logic        prv = 1'b0;

  logic [31:0] rd0, rd1;
  logic [3:0]  idx0, idx1, cnt0, cnt1;
  logic        emp0, emp1, ful0, ful1, ovf0, ovf1;
  logic [1:0]  err0, err1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_store #(.DATA_W(32), .DEPTH(10), .ERR_W(2), .OVERWRITE(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
    .nxt(nxt), .prv(prv), .rd_data(rd0), .rd_idx(idx0), .count(cnt0),
    .empty(emp0), .full(ful0), .err_out(err0), .ovf(ovf0));

  seq_store #(.DATA_W(32), .DEPTH(10), .ERR_W(2), .OVERWRITE(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
    .nxt(nxt), .prv(prv), .rd_data(rd1), .rd_idx(idx1), .count(cnt1),
    .empty(emp1), .full(ful1), .err_out(err1), .ovf(ovf1));

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] wd;
    logic [1:0]  werr;
    logic        n;
    logic        p;
    logic [3:0]  e_cnt;
    logic [3:0]  e_idx;
    logic [31:0] e_rd;
    logic [1:0]  e_err;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic rst, logic we, logic [31:0] wd, logic [1:0] werr,
                              logic n, logic p, logic [3:0] e_cnt, logic [3:0] e_idx,
                              logic [31:0] e_rd, logic [1:0] e_err, logic e_ovf);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.werr = werr; v.n = n; v.p = p;
    v.e_cnt = e_cnt; v.e_idx = e_idx; v.e_rd = e_rd; v.e_err = e_err; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock cycle: drive at negedge, sample 1ns after the rising edge
  task automatic cyc(input logic rst, input logic we, input logic [31:0] wd,
                     input logic [1:0] werr, input logic n, input logic p);
    @(negedge clk);
    reset = rst; wr_en = we; wr_data = wd; wr_err = werr; nxt = n; prv = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t e;
    string tag;

    // rst we data err nxt prv | cnt idx rd_data err ovf (all after the edge)
    tbl.push_back(mk(1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h00, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h11, 2'd0, 1'b0, 1'b0, 4'd1, 4'd0, 32'h00, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h22, 2'd0, 1'b0, 1'b0, 4'd2, 4'd0, 32'h11, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h33, 2'd0, 1'b0, 1'b0, 4'd3, 4'd0, 32'h11, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0, 4'd3, 4'd0, 32'h11, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 4'd3, 4'd1, 32'h11, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 4'd3, 4'd2, 32'h22, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 4'd3, 4'd0, 32'h33, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd3, 4'd2, 32'h11, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0, 4'd3, 4'd2, 32'h33, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b1, 4'd3, 4'd2, 32'h33, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h99, 2'd2, 1'b0, 1'b0, 4'd3, 4'd2, 32'h33, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h44, 2'd0, 1'b0, 1'b0, 4'd4, 4'd2, 32'h33, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h77, 2'd1, 1'b0, 1'b0, 4'd4, 4'd2, 32'h33, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd4, 4'd1, 32'h33, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0, 4'd4, 4'd1, 32'h22, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 32'hAB, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 32'h00, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h55, 2'd0, 1'b0, 1'b0, 4'd1, 4'd0, 32'h00, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h66, 2'd0, 1'b1, 1'b0, 4'd2, 4'd0, 32'h55, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 4'd2, 4'd1, 32'h55, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0, 4'd2, 4'd1, 32'h66, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 4'd2, 4'd0, 32'h66, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd2, 4'd1, 32'h55, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h00, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 32'h00, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 32'h00, 2'd0, 1'b0));

    // table vectors: expectation queued at drive time, popped after the edge
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; wr_en = tbl[i].we; wr_data = tbl[i].wd;
      wr_err = tbl[i].werr; nxt = tbl[i].n; prv = tbl[i].p;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tag = $sformatf("v%0d", i);
      check({tag, " count0"}, 32'(cnt0), 32'(e.e_cnt));
      check({tag, " rd_idx0"}, 32'(idx0), 32'(e.e_idx));
      check({tag, " rd_data0"}, rd0, e.e_rd);
      check({tag, " err_out0"}, 32'(err0), 32'(e.e_err));
      check({tag, " ovf0"}, 32'(ovf0), 32'(e.e_ovf));
      check({tag, " empty0"}, 32'(emp0), 32'(e.e_cnt == 4'd0));
      check({tag, " full0"}, 32'(ful0), 32'(e.e_cnt == 4'd10));
      check({tag, " count1"}, 32'(cnt1), 32'(e.e_cnt));
      check({tag, " rd_idx1"}, 32'(idx1), 32'(e.e_idx));
      check({tag, " rd_data1"}, rd1, e.e_rd);
      check({tag, " err_out1"}, 32'(err1), 32'(e.e_err));
    end

    // fill to the boundary: ten writes make both instances full with no overflow yet
    cyc(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    for (int v = 1; v <= 10; v++) begin
      cyc(1'b0, 1'b1, 32'(v), 2'b00, 1'b0, 1'b0);
    end
    check("fill10 count0", 32'(cnt0), 32'd10);
    check("fill10 full0", 32'(ful0), 32'd1);
    check("fill10 ovf0", 32'(ovf0), 32'd0);
    check("fill10 full1", 32'(ful1), 32'd1);
    check("fill10 ovf1", 32'(ovf1), 32'd0);

    // two writes while full: drop policy keeps 1..10, overwrite policy keeps 3..12
    cyc(1'b0, 1'b1, 32'd11, 2'b00, 1'b0, 1'b0);
    check("wr11 ovf0", 32'(ovf0), 32'd1);
    cyc(1'b0, 1'b1, 32'd12, 2'b00, 1'b0, 1'b0);
    idle();
    check("over count0", 32'(cnt0), 32'd10);
    check("over count1", 32'(cnt1), 32'd10);
    check("over ovf1", 32'(ovf1), 32'd1);
    check("over idx1", 32'(idx1), 32'd0);
    idle();
    check("oldest rd0", rd0, 32'd1);
    check("oldest rd1", rd1, 32'd3);

    // wrap back from 0 to the newest entry
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    check("wrap idx0", 32'(idx0), 32'd9);
    idle();
    check("newest rd0", rd0, 32'd10);
    check("newest rd1", rd1, 32'd12);

    // walk every slot forward; value 11 must never appear in the drop instance
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
      check($sformatf("walk%0d idx0", k), 32'(idx0), 32'(k));
      idle();
      check($sformatf("walk%0d rd0", k), rd0, 32'(k + 1));
      check($sformatf("walk%0d rd1", k), rd1, 32'(k + 3));
      check($sformatf("walk%0d no11", k), 32'(rd0 == 32'd11), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_store.md
Name: seq_store

Overview:
- Parametrised sequence store with a browse cursor.
- Sits between the input-capture FSM (result strobe, data and error code) and the seven-segment display driver.
- Accepts error-free results into a circular buffer of DEPTH entries and latches the error codes it rejects.
- Exposes one stored entry at a time. The user steps the cursor forward or back with debounced single-cycle pulses.

Parameters:
- DATA_W, 32, width of a stored entry
- DEPTH, 10, number of entries (>= 2)
- ERR_W, 2, width of the error code
- OVERWRITE, 0, full-buffer policy: 0 = drop the new entry; 1 = overwrite the oldest entry

Ports:
- clk  in  1  system clock; all state is updated on its rising edge
- reset  in  1  synchronous, active-high; clears all state
- wr_en  in  1  single-cycle result strobe from the FSM
- wr_data  in  DATA_W  result value, sampled when wr_en=1
- wr_err  in  ERR_W  result error code, sampled when wr_en=1; 0 means OK
- nxt  in  1  single-cycle pulse: advance the cursor
- prv  in  1  single-cycle pulse: move the cursor back
- rd_data  out  DATA_W  entry under the cursor (registered)
- rd_idx  out  IW=max(1,$clog2(DEPTH))  cursor position, 0 = oldest entry
- count  out  CW=$clog2(DEPTH+1)  number of valid entries
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err_out  out  ERR_W  latest nonzero wr_err; sticky
- ovf  out  1  sticky flag: a write arrived while full

Behaviour:
- Reset has priority over every other input in the same cycle.
- Reset values: count=0, head=0, rd_idx=0, rd_data=0, err_out=0, ovf=0, empty=1, full=0.
- Memory contents need not be cleared; count gates all visibility.
- Storage is circular. head points at the oldest entry. Entry i lives at (head+i) mod DEPTH, and wrap arithmetic never uses a power-of-two mask.
- Write with wr_en=1 and wr_err==0:
  - If count<DEPTH: store at (head+count) mod DEPTH and increment count.
  - If full and OVERWRITE=0: discard the data; set ovf; count, head and memory are unchanged.
  - If full and OVERWRITE=1: store at head; head=(head+1) mod DEPTH; count stays at DEPTH; set ovf. rd_idx is unchanged, so the view shifts to the next-newer entry.
- Write with wr_en=1 and wr_err!=0: err_out<=wr_err and nothing is stored. A later nonzero error replaces the earlier one. An OK write does not clear err_out.
- Cursor rules (n = count before this cycle's write):
  - nxt only: if n==0, rd_idx stays 0; otherwise rd_idx = (rd_idx==n-1) ? 0 : rd_idx+1.
  - prv only: if n==0, rd_idx stays 0; otherwise rd_idx = (rd_idx==0) ? n-1 : rd_idx-1.
  - nxt and prv in the same cycle: the cursor does not change.
  - A write in the same cycle as nxt/prv is performed. The cursor step uses the pre-write n, so the new entry becomes reachable from the next cycle onward.
- rd_data is registered, with one cycle of latency. rd_data <= (count==0) ? 0 : mem[(head+rd_idx) mod DEPTH], using the register values at the start of the cycle.
  - A cursor change or write at edge k is visible on rd_data after edge k+1.
- empty and full are decoded combinationally from registered count.
- No output toggles when no input event occurs.
- Expected implementation: a single always block for state, plus a separate rd_data register.

Test Plan:
- Reset, then 3 OK writes 0x11, 0x22, 0x33 -> count=3, rd_idx=0; two cycles after the last write, rd_data=0x11; empty=0, full=0.
- From that state: nxt x3 -> rd_idx 1, 2, 0 and rd_data 0x22, 0x33, 0x11; then prv -> rd_idx=2, rd_data=0x33.
- OVERWRITE=0, DEPTH=10: 11 OK writes of 1..11 -> count=10, full=1, ovf=1; rd_idx=9 shows 10; value 11 is absent.
- OVERWRITE=1: 12 writes of 1..12 -> count=10, ovf=1; rd_idx=0 shows 3 and rd_idx=9 shows 12.
- Write with wr_err=2, then an OK write of 0x44 -> err_out=2 in both cases and count increments only once; a later wr_err=1 -> err_out=1.
- Simultaneous events: nxt with prv -> rd_idx unchanged. Write with nxt on count=1 -> rd_idx stays 0 and count=2. reset with wr_en and nxt -> all outputs at their reset values on the next cycle.
